// File: rtl/polar_dec_pkg.sv
// Shared types, default sizes and helper functions for the polar decoder stores.
package polar_dec_pkg;

  localparam int Q_DEF     = 6;
  localparam int P_DEF     = 256;
  localparam int N_DEF     = 1024;
  localparam int LOG_N_DEF = 10;

  typedef logic signed [Q_DEF-1:0] llr_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Chunks occupied by a 2^l-element vector split into p-lane chunks (at least one).
  function automatic int layer_chunks(input int l, input int p);
    int n;
    if (l < 0 || l > 30) return 1;
    n = (1 << l) / p;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/alpha_layer_bank.sv
// One tree layer of alpha storage: chunked writes and left/right half-vector chunk reads.
module alpha_layer_bank
  import polar_dec_pkg::*;
#(
  parameter int Q     = 6,
  parameter int P     = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 3
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      w_en,
  input  logic [AW-1:0]                             w_addr,
  input  logic [((DEPTH < P) ? DEPTH : P)*Q-1:0]    w_data,
  input  logic [AW-1:0]                             r_addr,
  output logic [P*Q-1:0]                            left,
  output logic [P*Q-1:0]                            right
);

  localparam int W  = (DEPTH < P) ? DEPTH : P;
  localparam int WC = (DEPTH / P < 1) ? 1 : DEPTH / P;
  localparam int H  = DEPTH / 2;
  localparam int R  = (H < P) ? H : P;
  localparam int RC = (H / P < 1) ? 1 : H / P;

  logic [Q-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (w_en) begin
      for (int c = 0; c < WC; c++) begin
        if (w_addr == AW'(c)) begin
          for (int j = 0; j < W; j++) mem[c*P+j] <= w_data[j*Q+:Q];
        end
      end
    end
  end

  // Lanes at or above R stay zero; the right half starts at element H.
  always_comb begin
    left  = '0;
    right = '0;
    for (int c = 0; c < RC; c++) begin
      if (r_addr == AW'(c)) begin
        for (int i = 0; i < R; i++) begin
          left[i*Q+:Q]  = mem[c*P+i];
          right[i*Q+:Q] = mem[H+c*P+i];
        end
      end
    end
  end

endmodule

// File: rtl/alpha_layer_store.sv
// Per-layer alpha LLR store with range checking and registered left/right chunk reads.
// Build option: define ALPHA_FWD_EN for same-cycle write-to-read forwarding (default: read-before-write).
module alpha_layer_store
  import polar_dec_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int P = P_DEF,
  parameter int N = N_DEF,
  localparam int LOG_N = clog2(N),
  localparam int AW = clog2(N / P) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_en,
  input  logic [4:0]      layer_w,
  input  logic [AW-1:0]   w_addr,
  input  logic [P*Q-1:0]  a_in,
  input  logic            r_en,
  input  logic [4:0]      layer_r,
  input  logic [AW-1:0]   r_addr,
  output logic [P*Q-1:0]  a_out_left,
  output logic [P*Q-1:0]  a_out_right,
  output logic            a_valid,
  output logic            addr_err
);

  logic w_layer_ok, w_ok, r_layer_ok, r_ok, fwd_hit;
  logic [LOG_N:1][P*Q-1:0] mrg_left, mrg_right;
  logic [P*Q-1:0] sel_left, sel_right;

  assign w_layer_ok = (layer_w != 5'd0) && (int'(layer_w) <= LOG_N);
  assign r_layer_ok = (layer_r != 5'd0) && (int'(layer_r) <= LOG_N);
  assign w_ok = w_layer_ok && (int'(w_addr) < layer_chunks(int'(layer_w), P));
  // A read addresses half-vectors, so its chunk range is that of layer l-1.
  assign r_ok = r_layer_ok && (int'(r_addr) < layer_chunks(int'(layer_r) - 1, P));
  assign fwd_hit = w_en && w_ok && r_en && r_ok && (layer_w == layer_r);

  genvar gi;
  for (gi = 1; gi <= LOG_N; gi++) begin : g_layer
    localparam int DEPTH = 1 << gi;
    localparam int W = (DEPTH < P) ? DEPTH : P;

    logic [P*Q-1:0] bank_left, bank_right;
    logic           bank_w_en;

    assign bank_w_en = w_en && w_ok && (layer_w == 5'(gi));

    alpha_layer_bank #(
      .Q     (Q),
      .P     (P),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .w_en   (bank_w_en),
      .w_addr (w_addr),
      .w_data (a_in[W*Q-1:0]),
      .r_addr (r_addr),
      .left   (bank_left),
      .right  (bank_right)
    );

`ifdef ALPHA_FWD_EN
    localparam int H = DEPTH / 2;
    localparam int R = (H < P) ? H : P;

    logic [P*Q-1:0] fwd_left, fwd_right;
    logic           hit;

    assign hit = fwd_hit && (layer_w == 5'(gi));

    if (H >= P) begin : g_wide
      // Right chunk c lives at write chunk c + H/P.
      always_comb begin
        fwd_left  = bank_left;
        fwd_right = bank_right;
        if (hit && (w_addr == r_addr)) begin
          for (int i = 0; i < R; i++) fwd_left[i*Q+:Q] = a_in[i*Q+:Q];
        end
        if (hit && (int'(w_addr) == int'(r_addr) + H / P)) begin
          for (int i = 0; i < R; i++) fwd_right[i*Q+:Q] = a_in[i*Q+:Q];
        end
      end
    end else begin : g_narrow
      // Whole layer fits one chunk: both halves come from the single write.
      always_comb begin
        fwd_left  = bank_left;
        fwd_right = bank_right;
        if (hit) begin
          for (int i = 0; i < R; i++) begin
            fwd_left[i*Q+:Q]  = a_in[i*Q+:Q];
            fwd_right[i*Q+:Q] = a_in[(H+i)*Q+:Q];
          end
        end
      end
    end

    assign mrg_left[gi]  = fwd_left;
    assign mrg_right[gi] = fwd_right;
`else
    assign mrg_left[gi]  = bank_left;
    assign mrg_right[gi] = bank_right;
`endif
  end

  always_comb begin
    sel_left  = '0;
    sel_right = '0;
    for (int l = 1; l <= LOG_N; l++) begin
      if (layer_r == 5'(l)) begin
        sel_left  = mrg_left[l];
        sel_right = mrg_right[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_left  <= '0;
      a_out_right <= '0;
      a_valid     <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      a_valid <= r_en && r_ok;
      if (r_en && r_ok) begin
        a_out_left  <= sel_left;
        a_out_right <= sel_right;
      end else begin
        a_out_left  <= '0;
        a_out_right <= '0;
      end
      if ((w_en && !w_ok) || (r_en && !r_ok)) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alpha_layer_store.sv
// Directed bench for alpha_layer_store at N=16, P=4, Q=6; expectations follow ALPHA_FWD_EN.
module tb_alpha_layer_store;

  localparam int Q  = 6;
  localparam int P  = 4;
  localparam int N  = 16;
  localparam int AW = 3;

  logic            clk;
  logic            rst_n;
  logic            w_en;
  logic [4:0]      layer_w;
  logic [AW-1:0]   w_addr;
  logic [P*Q-1:0]  a_in;
  logic            r_en;
  logic [4:0]      layer_r;
  logic [AW-1:0]   r_addr;
  logic [P*Q-1:0]  a_out_left;
  logic [P*Q-1:0]  a_out_right;
  logic            a_valid;
  logic            addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  alpha_layer_store #(.Q(Q), .P(P), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .w_en        (w_en),
    .layer_w     (layer_w),
    .w_addr      (w_addr),
    .a_in        (a_in),
    .r_en        (r_en),
    .layer_r     (layer_r),
    .r_addr      (r_addr),
    .a_out_left  (a_out_left),
    .a_out_right (a_out_right),
    .a_valid     (a_valid),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [P*Q-1:0] v4(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int l, input int c, input logic [P*Q-1:0] d);
    w_en = 1'b1; layer_w = 5'(l); w_addr = AW'(c); a_in = d;
    tick();
    w_en = 1'b0;
    $display("[TB] wr layer %0d chunk %0d data %h err=%0d", l, c, d, addr_err);
  endtask

  // Issues one read; outputs reflect it when the task returns.
  task automatic do_read(input int l, input int c);
    r_en = 1'b1; layer_r = 5'(l); r_addr = AW'(c);
    tick();
    r_en = 1'b0;
    $display("[TB] rd layer %0d chunk %0d -> L=%h R=%h v=%0d err=%0d",
             l, c, a_out_left, a_out_right, a_valid, addr_err);
  endtask

  task automatic write_layer4();
    for (int c = 0; c < 4; c++) do_write(4, c, v4(4*c, 4*c+1, 4*c+2, 4*c+3));
  endtask

  initial begin
    rst_n = 1'b0; w_en = 1'b0; layer_w = '0; w_addr = '0; a_in = '0;
    r_en = 1'b0; layer_r = '0; r_addr = '0;
    #12;
    check("rst_left", a_out_left, '0);
    check("rst_valid", a_valid, 1'b0);
    check("rst_err", addr_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: full layer 4
    write_layer4();
    do_read(4, 0);
    check("l4c0_valid", a_valid, 1'b1);
    check("l4c0_left", a_out_left, v4(0, 1, 2, 3));
    check("l4c0_right", a_out_right, v4(8, 9, 10, 11));
    do_read(4, 1);
    check("l4c1_left", a_out_left, v4(4, 5, 6, 7));
    check("l4c1_right", a_out_right, v4(12, 13, 14, 15));
    tick();
    check("idle_valid", a_valid, 1'b0);
    check("idle_left", a_out_left, '0);

    // 2: narrow layers
    do_write(2, 0, v4(0, 1, 2, 3));
    do_write(1, 0, v4(0, 1, 2, 3));
    do_read(2, 0);
    check("l2_left", a_out_left, v4(0, 1, 0, 0));
    check("l2_right", a_out_right, v4(2, 3, 0, 0));
    do_read(1, 0);
    check("l1_left", a_out_left, v4(0, 0, 0, 0));
    check("l1_right", a_out_right, v4(1, 0, 0, 0));
    check("l1_valid", a_valid, 1'b1);
    check("no_err_yet", addr_err, 1'b0);

    // 3: illegal accesses
    do_write(3, 0, v4(0, 1, 2, 3));
    do_write(3, 1, v4(4, 5, 6, 7));
    check("l3_legal_err", addr_err, 1'b0);
    do_write(3, 2, v4(33, 33, 33, 33));
    check("bad_wr_err", addr_err, 1'b1);
    do_read(3, 0);
    check("l3_left_kept", a_out_left, v4(0, 1, 2, 3));
    check("l3_right_kept", a_out_right, v4(4, 5, 6, 7));
    do_read(5, 0);
    check("bad_rd_valid", a_valid, 1'b0);
    check("bad_rd_left", a_out_left, '0);
    check("bad_rd_right", a_out_right, '0);
    check("bad_rd_err", addr_err, 1'b1);
    do_read(4, 2);
    check("bad_chunk_valid", a_valid, 1'b0);

    // 4: same-cycle write and read of one location
    w_en = 1'b1; layer_w = 5'd4; w_addr = 3'd0; a_in = v4(9, 9, 9, 9);
    r_en = 1'b1; layer_r = 5'd4; r_addr = 3'd0;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    $display("[TB] wr+rd layer 4 chunk 0 -> L=%h R=%h", a_out_left, a_out_right);
`ifdef ALPHA_FWD_EN
    check("rw_left", a_out_left, v4(9, 9, 9, 9));
`else
    check("rw_left", a_out_left, v4(0, 1, 2, 3));
`endif
    check("rw_right", a_out_right, v4(8, 9, 10, 11));
    do_read(4, 0);
    check("rw_later_left", a_out_left, v4(9, 9, 9, 9));

    // 5: back-to-back reads with reset on the third
    r_en = 1'b1; layer_r = 5'd4; r_addr = 3'd1;
    tick();
    check("b2b1_valid", a_valid, 1'b1);
    check("b2b1_left", a_out_left, v4(4, 5, 6, 7));
    r_addr = 3'd0;
    tick();
    check("b2b2_valid", a_valid, 1'b1);
    check("b2b2_left", a_out_left, v4(9, 9, 9, 9));
    r_addr = 3'd1;
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-burst -> L=%h v=%0d", a_out_left, a_valid);
    check("arst_valid", a_valid, 1'b0);
    check("arst_left", a_out_left, '0);
    check("arst_right", a_out_right, '0);
    check("arst_err", addr_err, 1'b0);
    r_en = 1'b0;
    tick();
    rst_n = 1'b1;
    do_read(4, 0);
    check("post_rst_valid", a_valid, 1'b1);
    check("post_rst_left", a_out_left, '0);
    check("post_rst_right", a_out_right, '0);
    check("post_rst_err", addr_err, 1'b0);

    // 6: layer 3 writes interleaved with layer 4 reads
    write_layer4();
    for (int k = 0; k < 2; k++) begin
      w_en = 1'b1; layer_w = 5'd3; w_addr = AW'(k); a_in = v4(40+k, 41+k, 42+k, 43+k);
      r_en = 1'b1; layer_r = 5'd4; r_addr = AW'(k);
      tick();
      w_en = 1'b0; r_en = 1'b0;
      $display("[TB] wr l3 c%0d + rd l4 c%0d -> L=%h R=%h", k, k, a_out_left, a_out_right);
      check("mix_left", a_out_left, v4(4*k, 4*k+1, 4*k+2, 4*k+3));
      check("mix_right", a_out_right, v4(8+4*k, 9+4*k, 10+4*k, 11+4*k));
      check("mix_valid", a_valid, 1'b1);
    end
    do_read(3, 0);
    check("l3_new_left", a_out_left, v4(40, 41, 42, 43));
    check("l3_new_right", a_out_right, v4(41, 42, 43, 44));
    check("mix_err", addr_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
